// File: rtl/pipe_shift_reg.sv
// Elastic multi-stage pipeline register: per-stage valid bits, a valid/ready
// handshake with bubble collapse, synchronous reset/flush and an occupancy count.
module pipe_shift_reg #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inValid,
    input  logic [WIDTH-1:0] dataIn,
    output logic             inReady,
    input  logic             outReady,
    output logic             outValid,
    output logic [WIDTH-1:0] dataOut,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             in_fire;
    logic             out_fire;

    // A stage may load when the consumer is taking the tail word or any stage
    // at or downstream of it is empty; written per stage to avoid a ripple loop.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = outReady || (|(~v & ({DEPTH{1'b1}} << i)));
        end
    end

    assign inReady  = rdy[0];
    assign outValid = v[DEPTH-1];
    assign dataOut  = d[DEPTH-1];
    assign in_fire  = inValid && rdy[0];
    assign out_fire = v[DEPTH-1] && outReady;

    // NOTE: all sequential state uses non-blocking assignments so every stage
    // samples its upstream neighbour's pre-edge value.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            v     <= '0;
            count <= '0;
            // NOTE: the data stages are real flops (not a RAM), so clearing
            // them to RESET_VAL is cheap and makes dataOut defined after reset.
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= inValid;
                d[0] <= dataIn;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    d[i] <= d[i-1];
                end
            end
            unique case ({in_fire, out_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_shift_reg.sv
// Bench for pipe_shift_reg (WIDTH=32, DEPTH=4): directed vectors with literal
// expectations plus a per-cycle comparison against a slot-position model.
module tb_pipe_shift_reg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RST;
    logic             inValid;
    logic [WIDTH-1:0] dataIn;
    logic             inReady;
    logic             outReady;
    logic             outValid;
    logic [WIDTH-1:0] dataOut;
    logic             flush;
    logic [CNT_W-1:0] count;

    int tests  = 0;
    int failed = 0;

    pipe_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
        .CLK(CLK), .RST(RST), .inValid(inValid), .dataIn(dataIn),
        .inReady(inReady), .outReady(outReady), .outValid(outValid),
        .dataOut(dataOut), .flush(flush), .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the words in flight, oldest first, each with the stage it sits in.
    typedef struct {
        int          pos;
        logic [31:0] data;
    } item_t;
    item_t mq[$];
    bit    model_on = 0;

    // Each word steps one stage closer to the output if that stage is free
    // after the words ahead of it have moved; the oldest leaves from the last
    // stage when the consumer accepts. Returns whether stage 0 ends up free.
    function automatic bit model_moves(bit ordy, bit apply);
        int    limit = DEPTH;
        item_t nq[$];
        for (int k = 0; k < mq.size(); k++) begin
            int p = mq[k].pos;
            if (k == 0 && p == DEPTH - 1 && ordy) begin
                continue;
            end
            if (p + 1 < limit) p = p + 1;
            limit = p;
            nq.push_back('{pos: p, data: mq[k].data});
        end
        if (apply) mq = nq;
        return limit > 0;
    endfunction

    always @(posedge CLK) begin
        if (RST || flush) begin
            mq.delete();
            if (RST) model_on = 1;
        end else if (model_on) begin
            bit rdy0;
            rdy0 = model_moves(outReady, 1);
            if (inValid && rdy0) mq.push_back('{pos: 0, data: dataIn});
        end
    end

    always @(negedge CLK) begin
        if (model_on) begin
            bit exp_valid;
            exp_valid = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
            check("model_outValid", 32'(outValid), 32'(exp_valid));
            if (exp_valid) check("model_dataOut", dataOut, mq[0].data);
            check("model_count", 32'(count), 32'(mq.size()));
            check("model_inReady", 32'(inReady), 32'(model_moves(outReady, 0)));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; inValid = 1'b1; dataIn = 32'hDEAD; outReady = 1'b0; flush = 1'b0;

        // Reset held two cycles with a word offered.
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_outValid", 32'(outValid), 32'd0);
            check("rst_dataOut", dataOut, 32'h0);
            check("rst_count", 32'(count), 32'd0);
        end
        RST = 1'b0; inValid = 1'b0;
        #1;
        check("rst_inReady", 32'(inReady), 32'd1);

        // Streaming latency: accepted at edge 0, visible after edge 3.
        outReady = 1'b1;
        inValid = 1'b1; dataIn = 32'h11; step();
        dataIn = 32'h22; step();
        dataIn = 32'h33; step();
        inValid = 1'b0;
        check("lat_not_yet", 32'(outValid), 32'd0);
        step();
        check("lat_valid0", 32'(outValid), 32'd1);
        check("lat_data0", dataOut, 32'h11);
        step();
        check("lat_data1", dataOut, 32'h22);
        step();
        check("lat_data2", dataOut, 32'h33);
        step();
        check("lat_empty", 32'(outValid), 32'd0);
        check("lat_count", 32'(count), 32'd0);

        // Backpressure fill: only four of six words fit.
        outReady = 1'b0;
        for (int k = 0; k < 6; k++) begin
            inValid = 1'b1; dataIn = 32'hA0 + 32'(k);
            #1;
            check("bp_inReady", 32'(inReady), (k < 4) ? 32'd1 : 32'd0);
            step();
        end
        inValid = 1'b0;
        check("bp_count", 32'(count), 32'd4);
        check("bp_head", dataOut, 32'hA0);
        step();
        check("bp_hold", dataOut, 32'hA0);
        outReady = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            check("bp_drain", dataOut, 32'hA0 + 32'(k));
        end
        step();
        check("bp_done", 32'(outValid), 32'd0);

        // Bubble collapse under a stalled consumer.
        outReady = 1'b0;
        inValid = 1'b1; dataIn = 32'h1; step();
        inValid = 1'b0; step(); step();
        inValid = 1'b1; dataIn = 32'h2; step();
        inValid = 1'b0; step(); step();
        check("bub_count", 32'(count), 32'd2);
        check("bub_inReady", 32'(inReady), 32'd1);
        check("bub_head", dataOut, 32'h1);
        outReady = 1'b1; step();
        check("bub_second", dataOut, 32'h2);
        step();
        check("bub_empty", 32'(count), 32'd0);

        // Flush against concurrent input and output handshakes.
        outReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            inValid = 1'b1; dataIn = 32'hB0 + 32'(k); step();
        end
        check("fl_full", 32'(count), 32'd4);
        flush = 1'b1; inValid = 1'b1; dataIn = 32'hCC; outReady = 1'b1;
        step();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        #1;
        check("fl_count", 32'(count), 32'd0);
        check("fl_outValid", 32'(outValid), 32'd0);
        check("fl_dataOut", dataOut, 32'h0);
        check("fl_inReady", 32'(inReady), 32'd1);

        // Random traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            inValid  = 1'($urandom_range(0, 1));
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 99) < 2);
            dataIn   = $urandom;
            step();
        end
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (DEPTH + 2) step();
        check("end_empty", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
